// File: rtl/mac_pkg.sv
// Shared definitions for the mac_seq dot-product sequencer and its mac datapath:
// mode bit positions, operand/accumulator widths, the floating accumulator's zero
// exponent and the sequencer state encoding.
package mac_pkg;

    // Bit positions inside the one-hot mode word
    localparam int MODE_FP    = 0;
    localparam int MODE_INT_S = 1;
    localparam int MODE_INT_M = 2;
    localparam int MODE_INT_L = 3;

    // Operand and accumulator widths
    localparam int VAL_W  = 16;
    localparam int INT_W  = 24;
    localparam int FP_W   = 31;
    localparam int MANT_W = 26;

    // Floating accumulator is {exp[4:0], signed mantissa[25:0]}; a mantissa LSB
    // is worth 2^(exp-12), so EXP_ZERO is the exponent of a unit-scaled mantissa.
    localparam logic [4:0]      EXP_ZERO = 5'h0c;
    localparam logic [FP_W-1:0] FP_ZERO  = {EXP_ZERO, 26'h0};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when exactly one bit of the mode word is set
    function automatic logic is_onehot(input logic [3:0] m);
        return (m != 4'd0) && ((m & (m - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/mac_seq_mac.sv
// mac: purely combinational multiply-accumulate step.
// Integer modes multiply signed slices of value/weight (8, 12 or 16 bits) and add
// the product to ints with 24-bit wrap-around. Floating mode multiplies the full
// 16-bit signed operands, scales the product to the accumulator exponent
// (product * 2^(2-exp)), adds it to the mantissa and, on overflow, renormalises
// once by bumping the exponent; if that is still not enough the mantissa
// saturates. The accumulator that the current mode does not use passes through.
module mac
    import mac_pkg::*;
(
    input  logic [3:0]       mode,
    input  logic [VAL_W-1:0] value,
    input  logic [VAL_W-1:0] weight,
    input  logic [INT_W-1:0] ints,
    input  logic [FP_W-1:0]  fps,
    output logic [INT_W-1:0] intr,
    output logic [FP_W-1:0]  fpr
);

    logic signed [15:0] prod_s;
    logic signed [23:0] prod_m;
    logic signed [31:0] prod_l;
    logic [INT_W-1:0]   int_term;
    logic [4:0]         exp_in;
    logic signed [33:0] p_ext;
    logic signed [33:0] fp_term;
    logic [35:0]        fp_sum;
    logic               fits26;
    logic               fits27;

    assign prod_s = 16'($signed(value[7:0]))  * 16'($signed(weight[7:0]));
    assign prod_m = 24'($signed(value[11:0])) * 24'($signed(weight[11:0]));
    assign prod_l = 32'($signed(value))       * 32'($signed(weight));

    // Integer path: pick the product for the active width and add with wrap
    always_comb begin
        int_term = '0;
        if (mode[MODE_INT_S]) begin
            int_term = {{8{prod_s[15]}}, prod_s};
        end else if (mode[MODE_INT_M]) begin
            int_term = prod_m;
        end else if (mode[MODE_INT_L]) begin
            int_term = prod_l[23:0];
        end
        intr = ints + int_term;
    end

    // Floating path: scale product to the accumulator exponent, add, renormalise
    always_comb begin
        exp_in  = fps[30:26];
        p_ext   = {{2{prod_l[31]}}, prod_l};
        if (exp_in >= 5'd2) begin
            fp_term = p_ext >>> (exp_in - 5'd2);
        end else begin
            fp_term = p_ext <<< (5'd2 - exp_in);
        end
        fp_sum = {{2{fp_term[33]}}, fp_term} + {{10{fps[25]}}, fps[25:0]};
        fits26 = (&fp_sum[35:25]) | ~(|fp_sum[35:25]);
        fits27 = (&fp_sum[35:26]) | ~(|fp_sum[35:26]);
        if (!mode[MODE_FP]) begin
            fpr = fps;
        end else if (fits26) begin
            fpr = {exp_in, fp_sum[25:0]};
        end else if (fits27 && (exp_in != 5'd31)) begin
            fpr = {exp_in + 5'd1, fp_sum[26:1]};
        end else begin
            fpr = {exp_in, (fp_sum[35] ? 26'h2000000 : 26'h1ffffff)};
        end
    end

endmodule

// File: rtl/mac_seq.sv
// mac_seq: sequences a dot-product job over a value/weight stream.
// A start pulse in IDLE with a one-hot cfg_mode latches the mode and length and
// loads the accumulators; RUN accepts cfg_len pairs through the mac datapath;
// DONE presents the result until out_ready. Illegal starts pulse err.
// Optional feature: define MAC_SEQ_BIAS_EN to add bias_int/bias_fp ports that
// seed the accumulators instead of zero.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; in_ready is high only in RUN, out_valid only in DONE, and the result
// outputs are held constant while out_valid is high and out_ready is low.
module mac_seq
    import mac_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       cfg_mode,
    input  logic [7:0]       cfg_len,
`ifdef MAC_SEQ_BIAS_EN
    input  logic [INT_W-1:0] bias_int,
    input  logic [FP_W-1:0]  bias_fp,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAL_W-1:0] in_value,
    input  logic [VAL_W-1:0] in_weight,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_int,
    output logic [FP_W-1:0]  out_fp,
    output logic [3:0]       out_mode,
    output logic             busy,
    output logic             err
);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       mode_q;
    logic [7:0]       len_q;
    logic [7:0]       count_q;
    logic [INT_W-1:0] acc_int;
    logic [FP_W-1:0]  acc_fp;
    logic             err_q;
    logic [INT_W-1:0] intr;
    logic [FP_W-1:0]  fpr;
    logic [INT_W-1:0] load_int;
    logic [FP_W-1:0]  load_fp;
    logic             start_ok;
    logic             start_bad;
    logic             accept;
    logic             last_accept;

`ifdef MAC_SEQ_BIAS_EN
    assign load_int = bias_int;
    assign load_fp  = bias_fp;
`else
    assign load_int = '0;
    assign load_fp  = FP_ZERO;
`endif

    assign start_ok    = (state == ST_IDLE) && start && is_onehot(cfg_mode);
    assign start_bad   = (state == ST_IDLE) && start && !is_onehot(cfg_mode);
    assign accept      = in_valid && in_ready;
    // The count never wraps: the pair that reaches len ends the job
    assign last_accept = accept && ((count_q + 8'd1) == len_q);

    mac u_mac (
        .mode   (mode_q),
        .value  (in_value),
        .weight (in_weight),
        .ints   (acc_int),
        .fps    (acc_fp),
        .intr   (intr),
        .fpr    (fpr)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = (cfg_len == 8'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_accept) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded handshake and status outputs
    always_comb begin
        busy      = (state != ST_IDLE);
        in_ready  = (state == ST_RUN);
        out_valid = (state == ST_DONE);
    end

    // Job configuration, pair count and accumulators
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            acc_int <= '0;
            acc_fp  <= '0;
        end else if (start_ok) begin
            mode_q  <= cfg_mode;
            len_q   <= cfg_len;
            count_q <= '0;
            acc_int <= load_int;
            acc_fp  <= load_fp;
        end else if (accept) begin
            count_q <= count_q + 8'd1;
            acc_int <= intr;
            acc_fp  <= fpr;
        end
    end

    // One-cycle flag for a start with a malformed mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= start_bad;
        end
    end

    assign err      = err_q;
    assign out_int  = acc_int;
    assign out_fp   = acc_fp;
    assign out_mode = mode_q;

endmodule

// File: tb/tb_mac_seq.sv
// Testbench for mac_seq. Randomised jobs are scored against a reference model
// that computes each result with plain integer arithmetic. Build with
// MAC_SEQ_BIAS_EN defined to also exercise the accumulator bias ports.
module tb_mac_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  cfg_mode;
    logic [7:0]  cfg_len;
`ifdef MAC_SEQ_BIAS_EN
    logic [23:0] bias_int;
    logic [30:0] bias_fp;
`endif
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic [15:0] in_weight;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_int;
    logic [30:0] out_fp;
    logic [3:0]  out_mode;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected {mode, fp, int} of each finished job
    logic [58:0] exp_q[$];

    // Reference accumulators for the job in flight
    logic [23:0] m_int;
    logic [30:0] m_fp;
    logic [3:0]  m_mode;

    // Directed-operand and directed-bias overrides
    bit          fix_en = 1'b0;
    logic [15:0] fix_v;
    logic [15:0] fix_w;
    bit          bias_fix_en = 1'b0;
    logic [23:0] bias_fix_int;

    mac_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_mode  (cfg_mode),
        .cfg_len   (cfg_len),
`ifdef MAC_SEQ_BIAS_EN
        .bias_int  (bias_int),
        .bias_fp   (bias_fp),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_weight (in_weight),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_int   (out_int),
        .out_fp    (out_fp),
        .out_mode  (out_mode),
        .busy      (busy),
        .err       (err)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Reference: integer modes are signed slice products added modulo 2^24
    function automatic logic [23:0] model_int(input logic [3:0] mode, input logic [15:0] v,
                                              input logic [15:0] w, input logic [23:0] acc);
        longint a;
        longint b;
        a = 0;
        b = 0;
        if (mode[1]) begin
            a = longint'($signed(v[7:0]));
            b = longint'($signed(w[7:0]));
        end else if (mode[2]) begin
            a = longint'($signed(v[11:0]));
            b = longint'($signed(w[11:0]));
        end else if (mode[3]) begin
            a = longint'($signed(v));
            b = longint'($signed(w));
        end
        return 24'(longint'(acc) + a * b);
    endfunction

    // Reference: value = mant * 2^(exp-12); each step adds v*w/1024 at exp 12
    function automatic logic [30:0] model_fp(input logic [15:0] v, input logic [15:0] w,
                                             input logic [30:0] acc);
        int     e;
        longint m;
        longint p;
        longint t;
        longint s;
        longint h;
        longint lim25;
        longint lim26;
        logic [4:0]  eo;
        logic [25:0] mo;
        lim25 = 64'sd33554432;
        lim26 = 64'sd67108864;
        e = int'(acc[30:26]);
        m = longint'($signed(acc[25:0]));
        p = longint'($signed(v)) * longint'($signed(w));
        if (e >= 2) t = p >>> (e - 2);
        else        t = p * (longint'(1) << (2 - e));
        s = m + t;
        eo = 5'(e);
        if (s >= -lim25 && s < lim25) begin
            mo = 26'(s);
        end else if (s >= -lim26 && s < lim26 && e != 31) begin
            h  = s >>> 1;
            eo = 5'(e + 1);
            mo = 26'(h);
        end else begin
            mo = (s < 0) ? 26'h2000000 : 26'h1ffffff;
        end
        return {eo, mo};
    endfunction

    // Driver: one complete job; vmode 0=valid always, 1=toggling, 2=random
    task automatic run_job(input logic [3:0] mode, input logic [7:0] len, input int vmode,
                           input int stall, input bit start_in_run);
        int          acc_n;
        int          cyc;
        logic [58:0] e;
        @(negedge clk);
        start    = 1'b1;
        cfg_mode = mode;
        cfg_len  = len;
`ifdef MAC_SEQ_BIAS_EN
        bias_int = bias_fix_en ? bias_fix_int : 24'($urandom);
        bias_fp  = {5'($urandom_range(8, 16)), 26'($urandom)};
        m_int    = bias_int;
        m_fp     = bias_fp;
`else
        m_int    = 24'h0;
        m_fp     = {5'h0c, 26'h0};
`endif
        m_mode = mode;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        acc_n = 0;
        cyc   = 0;
        while (acc_n < int'(len) && cyc < 2000) begin
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_value  = fix_en ? fix_v : 16'($urandom);
            in_weight = fix_en ? fix_w : 16'($urandom);
            if (start_in_run && cyc == 0) begin
                start    = 1'b1;
                cfg_mode = (mode == 4'b1000) ? 4'b0001 : 4'b1000;
                cfg_len  = 8'd99;
            end else begin
                start = 1'b0;
            end
`ifdef MAC_SEQ_BIAS_EN
            if (bias_fix_en && cyc == 0) check("mac_ints", 64'(dut.u_mac.ints), 64'(bias_fix_int));
`endif
            if (in_valid && in_ready) begin
                m_int = model_int(m_mode, in_value, in_weight, m_int);
                if (m_mode[0]) m_fp = model_fp(in_value, in_weight, m_fp);
                acc_n++;
            end
            @(negedge clk);
            cyc++;
            if (start_in_run && cyc == 1) check("err_on_run_start", 64'(err), 64'd0);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check("accept_count", 64'(acc_n), 64'(len));
        if (vmode == 0) check("latency", 64'(cyc), 64'(len));
        exp_q.push_back({m_mode, m_fp, m_int});
        check("out_valid_done", 64'(out_valid), 64'd1);
        check("in_ready_done", 64'(in_ready), 64'd0);
        repeat (stall) begin
            check("stall_hold", 64'({out_mode, out_fp, out_int}), 64'(exp_q[0]));
            @(negedge clk);
        end
        check("out_valid_held", 64'(out_valid), 64'd1);
        e = exp_q.pop_front();
        check("result", 64'({out_mode, out_fp, out_int}), 64'(e));
        // start coinciding with the DONE handshake must not launch a job
        out_ready = 1'b1;
        start     = 1'b1;
        cfg_mode  = 4'b0010;
        cfg_len   = 8'd1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check("out_valid_drop", 64'(out_valid), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_err"},       64'(err),       64'd0);
        check({tag, "_in_ready"},  64'(in_ready),  64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_int"},   64'(out_int),   64'd0);
        check({tag, "_out_fp"},    64'(out_fp),    64'd0);
        check({tag, "_out_mode"},  64'(out_mode),  64'd0);
    endtask

    task automatic illegal_start(input logic [3:0] mode);
        @(negedge clk);
        start    = 1'b1;
        cfg_mode = mode;
        cfg_len  = 8'd3;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", 64'(err), 64'd1);
        check("err_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("err_clear", 64'(err), 64'd0);
        check("err_busy2", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [3:0] rmode;
        rst       = 1'b1;
        start     = 1'b0;
        cfg_mode  = 4'd0;
        cfg_len   = 8'd0;
        in_valid  = 1'b0;
        in_value  = 16'd0;
        in_weight = 16'd0;
        out_ready = 1'b0;
`ifdef MAC_SEQ_BIAS_EN
        bias_int  = 24'd0;
        bias_fp   = 31'd0;
`endif
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // int_s single directed pair
        fix_en = 1'b1;
        fix_v  = 16'he678;
        fix_w  = 16'h6789;
        run_job(4'b0010, 8'd1, 0, 0, 1'b0);
        fix_en = 1'b0;

        // int_l, 4 pairs with toggling valid, 2 stall cycles
        run_job(4'b1000, 8'd4, 1, 2, 1'b0);

        // fp, empty job, result held through 5 stalled cycles
        run_job(4'b0001, 8'd0, 0, 5, 1'b0);
`ifndef MAC_SEQ_BIAS_EN
        check("fp_zero_const", 64'(m_fp), 64'({5'h0c, 26'h0}));
`endif

        // malformed starts, then a start issued while running
        illegal_start(4'b0110);
        illegal_start(4'b0000);
        run_job(4'b0100, 8'd3, 1, 1, 1'b1);

        // reset in the middle of a job
        @(negedge clk);
        start    = 1'b1;
        cfg_mode = 4'b0010;
        cfg_len  = 8'd3;
        @(negedge clk);
        start     = 1'b0;
        in_valid  = 1'b1;
        in_value  = 16'h7f7f;
        in_weight = 16'h7f7f;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_all_zero("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        run_job(4'b0010, 8'd3, 2, 1, 1'b0);

        // longest job
        run_job(4'b1000, 8'd255, 2, 0, 1'b0);

        // random jobs
        for (int i = 0; i < 24; i++) begin
            rmode = 4'b0001 << $urandom_range(0, 3);
            run_job(rmode, 8'($urandom_range(0, 9)), $urandom_range(0, 2),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

`ifdef MAC_SEQ_BIAS_EN
        bias_fix_en  = 1'b1;
        bias_fix_int = 24'h345678;
        run_job(4'b0100, 8'd1, 0, 0, 1'b0);
        bias_fix_en  = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
